pe_layer_seq: RTL and testbench

- Per-PE layer sequencer FSM that drives the PE datapath across DNN layers once the PE state registers are configured.
- Drives `layer_idx` into the state-register block and reads back `layer_no`, `in_act_no`, `col_dim` and `w_mem_offset`.
- For each input activation it accepts, it issues `col_dim` consecutive weight-memory reads and tags them for the MAC array.
- Between layers it holds at a global barrier handshake.

---
 rtl/pe_layer_seq_pkg.sv | 19 +
 rtl/pe_layer_seq_addr_gen.sv | 46 ++++
 rtl/pe_layer_seq.sv | 169 ++++++++++++++++
 tb/tb_pe_layer_seq.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_layer_seq_pkg.sv
// Shared definitions for the PE layer sequencer: bus widths and the FSM state encoding.
package pe_layer_seq_pkg;

    localparam int PE_LAYER_W = 3;
    localparam int PE_ACT_W   = 6;
    localparam int PE_COL_W   = 6;
    localparam int PE_WADDR_W = 10;
    localparam int PE_DATA_W  = 16;

    typedef enum logic [2:0] {
        SEQ_IDLE      = 3'd0,
        SEQ_WAIT_ACT  = 3'd1,
        SEQ_READ_W    = 3'd2,
        SEQ_LAYER_END = 3'd3,
        SEQ_SYNC      = 3'd4,
        SEQ_FINISH    = 3'd5
    } seq_state_e;

endpackage

// File: rtl/pe_layer_seq_addr_gen.sv
// Weight address generator: per-layer base register, column counter and base advance by col_dim.
module pe_layer_seq_addr_gen
    import pe_layer_seq_pkg::*;
#(
    parameter int COL_W   = PE_COL_W,
    parameter int WADDR_W = PE_WADDR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_base,
    input  logic [WADDR_W-1:0] base_in,
    input  logic               col_clr,
    input  logic               col_step,
    input  logic [COL_W-1:0]   col_dim,
    output logic [WADDR_W-1:0] rd_addr,
    output logic [COL_W-1:0]   col_cnt,
    output logic               col_last
);

    logic [WADDR_W-1:0] base;

    assign col_last = (col_cnt == col_dim - COL_W'(1));
    assign rd_addr  = base + WADDR_W'(col_cnt);

    // Base moves past the current activation's weights once its last column is read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base <= '0;
        end else if (load_base) begin
            base <= base_in;
        end else if (col_step && col_last) begin
            base <= base + WADDR_W'(col_dim);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt <= '0;
        end else if (col_clr) begin
            col_cnt <= '0;
        end else if (col_step) begin
            col_cnt <= col_cnt + COL_W'(1);
        end
    end

endmodule

// File: rtl/pe_layer_seq.sv
// Per-PE layer sequencer: accepts activations, issues col_dim weight reads per activation,
// and holds at a global barrier between layers.
module pe_layer_seq
    import pe_layer_seq_pkg::*;
#(
    parameter int LAYER_W = PE_LAYER_W,
    parameter int ACT_W   = PE_ACT_W,
    parameter int COL_W   = PE_COL_W,
    parameter int WADDR_W = PE_WADDR_W,
    parameter int DATA_W  = PE_DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [LAYER_W-1:0] layer_no,
    input  logic [ACT_W-1:0]   in_act_no,
    input  logic [COL_W-1:0]   col_dim,
    input  logic [WADDR_W-1:0] w_mem_offset,
    output logic [LAYER_W-1:0] layer_idx,
    input  logic               act_valid,
    input  logic [DATA_W-1:0]  act_data,
    output logic               act_ready,
    output logic               w_rd_en,
    output logic [WADDR_W-1:0] w_rd_addr,
    output logic               mac_valid,
    output logic [DATA_W-1:0]  mac_act,
    output logic [COL_W-1:0]   mac_col,
    output logic               sync_req,
    input  logic               sync_ack,
    output logic               busy,
    output logic               done
);

    seq_state_e         state, next_state;
    logic [ACT_W-1:0]   act_cnt;
    logic [DATA_W-1:0]  act_reg;
    logic               load_pending;
    logic               start_run, next_layer, act_fire, col_last;
    logic [WADDR_W-1:0] rd_addr;
    logic [COL_W-1:0]   col_cnt;

    assign act_fire = act_ready & act_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEQ_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        act_ready  = 1'b0;
        w_rd_en    = 1'b0;
        sync_req   = 1'b0;
        done       = 1'b0;
        busy       = 1'b0;
        start_run  = 1'b0;
        next_layer = 1'b0;
        case (state)
            SEQ_IDLE: begin
                if (start) begin
                    if (layer_no == '0) begin
                        next_state = SEQ_FINISH;
                    end else begin
                        next_state = SEQ_WAIT_ACT;
                        start_run  = 1'b1;
                    end
                end
            end
            SEQ_WAIT_ACT: begin
                busy = 1'b1;
                if (act_cnt == in_act_no) begin
                    next_state = SEQ_LAYER_END;
                end else begin
                    act_ready = 1'b1;
                    if (act_valid && (col_dim != '0)) begin
                        next_state = SEQ_READ_W;
                    end
                end
            end
            SEQ_READ_W: begin
                busy    = 1'b1;
                w_rd_en = 1'b1;
                if (col_last) begin
                    next_state = SEQ_WAIT_ACT;
                end
            end
            SEQ_LAYER_END: begin
                busy       = 1'b1;
                next_state = SEQ_SYNC;
            end
            SEQ_SYNC: begin
                busy     = 1'b1;
                sync_req = 1'b1;
                if (sync_ack) begin
                    if (layer_idx == layer_no - LAYER_W'(1)) begin
                        next_state = SEQ_FINISH;
                    end else begin
                        next_state = SEQ_WAIT_ACT;
                        next_layer = 1'b1;
                    end
                end
            end
            SEQ_FINISH: begin
                done       = 1'b1;
                next_state = SEQ_IDLE;
            end
            default: next_state = SEQ_IDLE;
        endcase
    end

    // load_pending marks the WAIT_ACT entry cycle, when w_mem_offset already reflects layer_idx.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layer_idx    <= '0;
            act_cnt      <= '0;
            act_reg      <= '0;
            load_pending <= 1'b0;
        end else if (start_run) begin
            layer_idx    <= '0;
            act_cnt      <= '0;
            load_pending <= 1'b1;
        end else if (next_layer) begin
            layer_idx    <= layer_idx + LAYER_W'(1);
            act_cnt      <= '0;
            load_pending <= 1'b1;
        end else begin
            load_pending <= 1'b0;
            if (act_fire) begin
                act_cnt <= act_cnt + ACT_W'(1);
                act_reg <= act_data;
            end
        end
    end

    pe_layer_seq_addr_gen #(
        .COL_W   (COL_W),
        .WADDR_W (WADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_base (load_pending),
        .base_in   (w_mem_offset),
        .col_clr   (act_fire),
        .col_step  (w_rd_en),
        .col_dim   (col_dim),
        .rd_addr   (rd_addr),
        .col_cnt   (col_cnt),
        .col_last  (col_last)
    );

    assign w_rd_addr = w_rd_en ? rd_addr : '0;

    // Weight data returns one cycle after the read strobe, so the MAC tags are delayed to match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_valid <= 1'b0;
            mac_act   <= '0;
            mac_col   <= '0;
        end else begin
            mac_valid <= w_rd_en;
            mac_act   <= act_reg;
            mac_col   <= col_cnt;
        end
    end

endmodule

// File: tb/tb_pe_layer_seq.sv
// Self-checking bench for pe_layer_seq: table of whole-inference runs plus a mid-read reset sequence.
module tb_pe_layer_seq;

    localparam int LAYER_W = 3;
    localparam int ACT_W   = 6;
    localparam int COL_W   = 6;
    localparam int WADDR_W = 10;
    localparam int DATA_W  = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [LAYER_W-1:0] layer_no;
    logic [ACT_W-1:0]   in_act_no;
    logic [COL_W-1:0]   col_dim;
    logic [WADDR_W-1:0] w_mem_offset;
    logic [LAYER_W-1:0] layer_idx;
    logic               act_valid;
    logic [DATA_W-1:0]  act_data;
    logic               act_ready;
    logic               w_rd_en;
    logic [WADDR_W-1:0] w_rd_addr;
    logic               mac_valid;
    logic [DATA_W-1:0]  mac_act;
    logic [COL_W-1:0]   mac_col;
    logic               sync_req;
    logic               sync_ack;
    logic               busy;
    logic               done;

    int cfg_act [8];
    int cfg_col [8];
    int cfg_off [8];
    int act_base, act_step;
    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int addr;
        int act;
        int col;
        int layer;
    } rd_t;
    rd_t exp_q[$];

    typedef struct {
        int layers;
        int a0; int c0; int o0;
        int a1; int c1; int o1;
        int abase; int astep;
        bit rnd;
        int exp_reads; int exp_first; int exp_last; int exp_done;
    } vec_t;
    vec_t tbl[8];

    pe_layer_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .layer_no     (layer_no),
        .in_act_no    (in_act_no),
        .col_dim      (col_dim),
        .w_mem_offset (w_mem_offset),
        .layer_idx    (layer_idx),
        .act_valid    (act_valid),
        .act_data     (act_data),
        .act_ready    (act_ready),
        .w_rd_en      (w_rd_en),
        .w_rd_addr    (w_rd_addr),
        .mac_valid    (mac_valid),
        .mac_act      (mac_act),
        .mac_col      (mac_col),
        .sync_req     (sync_req),
        .sync_ack     (sync_ack),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Stands in for the PE state-register block, answering layer_idx with that layer's config.
    always_comb begin
        in_act_no    = ACT_W'(cfg_act[layer_idx]);
        col_dim      = COL_W'(cfg_col[layer_idx]);
        w_mem_offset = WADDR_W'(cfg_off[layer_idx]);
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_vec++;
        if (actual != expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic [DATA_W-1:0] act_val(input int k);
        return DATA_W'(act_base + k * act_step);
    endfunction

    task automatic loadConfig(input int idx);
        cfg_act[0] = tbl[idx].a0; cfg_col[0] = tbl[idx].c0; cfg_off[0] = tbl[idx].o0;
        cfg_act[1] = tbl[idx].a1; cfg_col[1] = tbl[idx].c1; cfg_off[1] = tbl[idx].o1;
        layer_no   = LAYER_W'(tbl[idx].layers);
        act_base   = tbl[idx].abase;
        act_step   = tbl[idx].astep;
    endtask

    task automatic applyStimulus(input int idx);
        vec_t  v;
        int    n_rd, n_hs, n_sync, n_done, done_cyc, exp_hs, first_addr, last_addr;
        int    prev_idx, act_ptr, k, budget, na, nc, off;
        bit    prev_rd, hs, last_sync, last_busy, done_seen;
        string tag;
        v = tbl[idx];
        tag = $sformatf("v%0d", idx);
        loadConfig(idx);
        exp_q.delete();
        k = 0; exp_hs = 0;
        for (int l = 0; l < v.layers; l++) begin
            na  = (l == 0) ? v.a0 : v.a1;
            nc  = (l == 0) ? v.c0 : v.c1;
            off = (l == 0) ? v.o0 : v.o1;
            for (int i = 0; i < na; i++) begin
                for (int c = 0; c < nc; c++)
                    exp_q.push_back('{(off + i * nc + c) % 1024, int'(act_val(k)), c, l});
                k++;
            end
            exp_hs += na;
        end
        n_rd = 0; n_hs = 0; n_sync = 0; n_done = 0; done_cyc = -1;
        first_addr = -1; last_addr = -1; prev_idx = 0; act_ptr = 0;
        prev_rd = 0; last_sync = 0; last_busy = 0; done_seen = 0;
        budget = v.rnd ? 600 : 200;

        @(posedge clk); #1;
        start = 1'b1; act_valid = 1'b1; act_data = act_val(0); sync_ack = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        act_valid = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;

        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            checkOutput($sformatf("%s_mac_valid_c%0d", tag, cyc), int'(mac_valid), int'(prev_rd));
            if (mac_valid && prev_rd) begin
                checkOutput($sformatf("%s_mac_act_r%0d", tag, prev_idx), int'(mac_act), exp_q[prev_idx].act);
                checkOutput($sformatf("%s_mac_col_r%0d", tag, prev_idx), int'(mac_col), exp_q[prev_idx].col);
            end
            prev_rd = 0;
            if (w_rd_en) begin
                if (n_rd < exp_q.size()) begin
                    checkOutput($sformatf("%s_addr_r%0d", tag, n_rd), int'(w_rd_addr), exp_q[n_rd].addr);
                    checkOutput($sformatf("%s_layer_r%0d", tag, n_rd), int'(layer_idx), exp_q[n_rd].layer);
                    prev_rd = 1; prev_idx = n_rd;
                end else begin
                    checkOutput($sformatf("%s_extra_read", tag), n_rd + 1, exp_q.size());
                end
                if (first_addr < 0) first_addr = int'(w_rd_addr);
                last_addr = int'(w_rd_addr);
                n_rd++;
            end
            if (cyc == 1) checkOutput($sformatf("%s_busy_first", tag), int'(busy), int'(v.layers != 0));
            hs = act_valid && act_ready;
            if (hs) n_hs++;
            if (sync_req && sync_ack) n_sync++;
            if (done) begin
                n_done++;
                if (!done_seen) begin
                    done_seen = 1; done_cyc = cyc;
                    checkOutput($sformatf("%s_busy_at_done", tag), int'(busy), 0);
                    checkOutput($sformatf("%s_sync_at_done", tag), int'(sync_req), 0);
                end
            end
            last_sync = sync_req;
            last_busy = busy;
            if (done_seen && cyc >= done_cyc + 3) break;
            @(posedge clk); #1;
            if (hs) begin
                act_ptr++;
                act_data = act_val(act_ptr);
            end
            act_valid = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            sync_ack  = v.rnd ? 1'($urandom_range(0, 1)) : last_sync;
            start     = v.rnd && last_busy && !done_seen && ($urandom_range(0, 3) == 0);
        end
        start = 1'b0; act_valid = 1'b0; sync_ack = 1'b0;

        checkOutput($sformatf("%s_read_count", tag), n_rd, v.exp_reads);
        checkOutput($sformatf("%s_handshakes", tag), n_hs, exp_hs);
        checkOutput($sformatf("%s_done_count", tag), n_done, 1);
        checkOutput($sformatf("%s_sync_count", tag), n_sync, v.layers);
        if (v.exp_done >= 0)
            checkOutput($sformatf("%s_done_cycle", tag), done_cyc, v.exp_done);
        if (v.exp_reads > 0) begin
            checkOutput($sformatf("%s_first_addr", tag), first_addr, v.exp_first);
            checkOutput($sformatf("%s_last_addr", tag), last_addr, v.exp_last);
        end
        checkOutput($sformatf("%s_busy_after", tag), int'(busy), 0);
    endtask

    initial begin
        bit found;
        bit ls;
        rst_n = 1'b0; start = 1'b0; act_valid = 1'b0; act_data = '0; sync_ack = 1'b0;
        layer_no = '0;
        for (int i = 0; i < 8; i++) begin
            cfg_act[i] = 0; cfg_col[i] = 0; cfg_off[i] = 0;
        end
        act_base = 0; act_step = 0;

        //          layers a0 c0 o0    a1 c1 o1   base step rnd reads first last done
        tbl[0] = '{1,      2, 3, 100,  0, 0, 0,   7,   2,   0,  6,    100,  105, 13};
        tbl[1] = '{2,      1, 1, 40,   1, 2, 500, 3,   1,   0,  3,    40,   501, 14};
        tbl[2] = '{1,      0, 5, 7,    0, 0, 0,   1,   1,   0,  0,    0,    0,   5};
        tbl[3] = '{1,      3, 0, 9,    0, 0, 0,   20,  5,   0,  0,    0,    0,   8};
        tbl[4] = '{0,      2, 2, 30,   0, 0, 0,   1,   1,   0,  0,    0,    0,   1};
        tbl[5] = '{1,      1, 4, 1022, 0, 0, 0,   11,  1,   0,  4,    1022, 1,   10};
        tbl[6] = '{1,      2, 3, 1020, 0, 0, 0,   40,  1,   0,  6,    1020, 1,   13};
        tbl[7] = '{2,      3, 2, 10,   2, 3, 200, 80,  3,   1,  12,   10,   205, -1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_w_rd_en", int'(w_rd_en), 0);
        checkOutput("rst_w_rd_addr", int'(w_rd_addr), 0);
        checkOutput("rst_act_ready", int'(act_ready), 0);
        checkOutput("rst_mac_valid", int'(mac_valid), 0);
        checkOutput("rst_mac_act", int'(mac_act), 0);
        checkOutput("rst_mac_col", int'(mac_col), 0);
        checkOutput("rst_sync_req", int'(sync_req), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_layer_idx", int'(layer_idx), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) applyStimulus(i);

        // Reset while reading weights of the second layer, then prove a clean restart.
        loadConfig(1);
        @(posedge clk); #1;
        start = 1'b1; act_valid = 1'b1; act_data = act_val(0);
        @(posedge clk); #1;
        start = 1'b0;
        found = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (w_rd_en && layer_idx == 3'd1) begin
                found = 1;
                break;
            end
            ls = sync_req;
            @(posedge clk); #1;
            sync_ack = ls;
        end
        checkOutput("mid_reset_reached_read", int'(found), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_reset_w_rd_en", int'(w_rd_en), 0);
        checkOutput("mid_reset_busy", int'(busy), 0);
        checkOutput("mid_reset_layer_idx", int'(layer_idx), 0);
        checkOutput("mid_reset_mac_valid", int'(mac_valid), 0);
        checkOutput("mid_reset_act_ready", int'(act_ready), 0);
        act_valid = 1'b0; sync_ack = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        applyStimulus(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
